// File: rtl/resilient_ctrl.sv
// Synchronous timing-resilient pipeline-stage controller: 4-phase left/right handshake,
// dual-rail error sampling with recovery delay, adaptive safe mode and a saturating error count.
module resilient_ctrl #(
  parameter int NUM_ERR      = 2,
  parameter int SAMPLE_DLY   = 3,
  parameter int EXTRA_DLY    = 2,
  parameter int RECOVER_DLY  = 2,
  parameter int ADAPT_THRESH = 2,
  parameter int SAFE_LEN     = 4,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lreq,
  output logic               lack,
  output logic               rreq,
  input  logic               rack,
  output logic               latch_en,
  output logic               sample,
  input  logic [NUM_ERR-1:0] err0,
  input  logic [NUM_ERR-1:0] err1,
  input  logic               err_clr,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               safe_mode
);

  localparam int DMAX = (SAMPLE_DLY + EXTRA_DLY > RECOVER_DLY) ? SAMPLE_DLY + EXTRA_DLY : RECOVER_DLY;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int EW   = $clog2(ADAPT_THRESH + 1);
  localparam int SW   = $clog2(SAFE_LEN + 1);

  localparam logic [DW-1:0] D_NORM = DW'(SAMPLE_DLY - 1);
  localparam logic [DW-1:0] D_SAFE = DW'(SAMPLE_DLY + EXTRA_DLY - 1);
  localparam logic [DW-1:0] D_REC  = DW'(RECOVER_DLY - 1);

  typedef enum logic [2:0] {IDLE, LATCH, DELAY, SAMPLE, RECOVER, REQ, RET} state_e;

  state_e           state_q, state_d;
  logic             lack_q, lack_d, rreq_q, rreq_d, latch_q, latch_d;
  logic             sample_q, sample_d, safe_q, safe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dly_q, dly_d;
  logic [EW-1:0]    cerr_q, cerr_d;
  logic [SW-1:0]    cclean_q, cclean_d;

  logic [NUM_ERR-1:0] resolved;
  logic               all_res, any_err, det_zero;

  // A channel is resolved on either single rail or the illegal both-rails code.
  for (genvar i = 0; i < NUM_ERR; i++) begin : g_chan
    assign resolved[i] = err0[i] | err1[i];
  end

  assign all_res  = &resolved;
  assign any_err  = |err1;
  assign det_zero = ~|resolved;

  always_comb begin
    state_d  = state_q;
    lack_d   = lack_q;
    rreq_d   = rreq_q;
    latch_d  = 1'b0;
    sample_d = sample_q;
    safe_d   = safe_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    cerr_d   = cerr_q;
    cclean_d = cclean_q;

    if (lack_q && !lreq) lack_d = 1'b0;

    case (state_q)
      IDLE: if (lreq && !lack_q && !rack) begin
        state_d = LATCH;
        latch_d = 1'b1;
        lack_d  = 1'b1;
      end
      LATCH: begin
        state_d = DELAY;
        dly_d   = safe_q ? D_SAFE : D_NORM;
      end
      DELAY: if (dly_q == '0) begin
        state_d  = SAMPLE;
        sample_d = 1'b1;
      end else begin
        dly_d = dly_q - 1'b1;
      end
      SAMPLE: if (all_res) begin
        sample_d = 1'b0;
        if (any_err) begin
          state_d  = RECOVER;
          dly_d    = D_REC;
          cclean_d = '0;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (int'(cerr_q) < ADAPT_THRESH) cerr_d = cerr_q + 1'b1;
          if (int'(cerr_q) + 1 >= ADAPT_THRESH) safe_d = 1'b1;
        end else begin
          state_d = REQ;
          rreq_d  = 1'b1;
          cerr_d  = '0;
          if (int'(cclean_q) < SAFE_LEN) cclean_d = cclean_q + 1'b1;
          if (int'(cclean_q) + 1 >= SAFE_LEN) safe_d = 1'b0;
        end
      end
      RECOVER: if (dly_q == '0) begin
        state_d = REQ;
        rreq_d  = 1'b1;
      end else begin
        dly_d = dly_q - 1'b1;
      end
      REQ: if (rack) begin
        state_d = RET;
        rreq_d  = 1'b0;
      end
      RET: if (!rack && det_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (err_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lack_q   <= 1'b0;
      rreq_q   <= 1'b0;
      latch_q  <= 1'b0;
      sample_q <= 1'b0;
      safe_q   <= 1'b0;
      cnt_q    <= '0;
      dly_q    <= '0;
      cerr_q   <= '0;
      cclean_q <= '0;
    end else begin
      state_q  <= state_d;
      lack_q   <= lack_d;
      rreq_q   <= rreq_d;
      latch_q  <= latch_d;
      sample_q <= sample_d;
      safe_q   <= safe_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      cerr_q   <= cerr_d;
      cclean_q <= cclean_d;
    end
  end

  assign lack      = lack_q;
  assign rreq      = rreq_q;
  assign latch_en  = latch_q;
  assign sample    = sample_q;
  assign err_cnt   = cnt_q;
  assign safe_mode = safe_q;

endmodule
